serial_adder_seq: RTL and testbench

Bit-serial add controller that drives the team's 1-bit full adder from the far side of its interface. It accepts two WIDTH-bit operands and a carry-in in parallel, presents them to the external 1-bit adder one bit per clock, LSB first, and threads the carry through a register. It collects the returned sum bits into a parallel result. It sits between the chip-level input pins and the 1-bit adder cell, turning the single-bit adder into a multi-bit adder.

---
 rtl/serial_adder_seq.sv | 101 ++++++++++
 tb/tb_serial_adder_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial add controller: feeds an external 1-bit full adder LSB first,
// threads the carry through a register and gathers the sum bits in parallel.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             bit_a,
    output logic             bit_b,
    output logic             bit_cin,
    input  logic             bit_sum,
    input  logic             bit_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             carry;
    logic [CW-1:0]    count;

    // Each returned sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
    assign result_next = (result >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

    assign bit_a   = busy & a_shift[0];
    assign bit_b   = busy & b_shift[0];
    assign bit_cin = busy & carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            a_shift <= '0;
            b_shift <= '0;
            result  <= '0;
            carry   <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_shift <= a;
                        b_shift <= b;
                        carry   <= cin;
                        result  <= '0;
                        count   <= '0;
                        state   <= RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    a_shift <= a_shift >> 1;
                    b_shift <= b_shift >> 1;
                    carry   <= bit_cout;
                    result  <= result_next;
                    count   <= count + CW'(1);
                    // sum/cout are only ever updated here, so they never show partial values
                    if (count == LAST) begin
                        sum   <= result_next;
                        cout  <= bit_cout;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq at WIDTH=8 and WIDTH=1, each driving
// a behavioural 1-bit full adder on its serial port.
module tb_serial_adder_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       bit_a8, bit_b8, bit_cin8, bit_sum8, bit_cout8;

    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic       bit_a1, bit_b1, bit_cin1, bit_sum1, bit_cout1;

    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];

    // Reference 1-bit full adders sitting on the far side of each serial port
    assign bit_sum8  = bit_a8 ^ bit_b8 ^ bit_cin8;
    assign bit_cout8 = (bit_a8 & bit_b8) | (bit_a8 & bit_cin8) | (bit_b8 & bit_cin8);
    assign bit_sum1  = bit_a1 ^ bit_b1 ^ bit_cin1;
    assign bit_cout1 = (bit_a1 & bit_b1) | (bit_a1 & bit_cin1) | (bit_b1 & bit_cin1);

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .bit_a(bit_a8), .bit_b(bit_b8), .bit_cin(bit_cin8),
        .bit_sum(bit_sum8), .bit_cout(bit_cout8)
    );

    serial_adder_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .bit_a(bit_a1), .bit_b(bit_b1), .bit_cin(bit_cin1),
        .bit_sum(bit_sum1), .bit_cout(bit_cout1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every done pulse must match the oldest outstanding accepted operation
    always @(negedge clk) begin
        if (done8) begin
            if (exp8_q.size() == 0) checkOutput("done8_unexpected", done8, 1'b0);
            else checkOutput("result8", {cout8, sum8}, exp8_q.pop_front());
        end
        if (done1) begin
            if (exp1_q.size() == 0) checkOutput("done1_unexpected", done1, 1'b0);
            else checkOutput("result1", {cout1, sum1}, exp1_q.pop_front());
        end
    end

    task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv,
                                  input logic cv, input bit hold);
        int waited = 0;
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        while (!ready8 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready8_wait", ready8, 1'b1);
        exp8_q.push_back(9'(av) + 9'(bv) + 9'(cv));
        @(posedge clk);
        #1;
        if (!hold) start8 = 1'b0;
    endtask

    task automatic applyStimulus1(input logic av, input logic bv, input logic cv);
        int waited = 0;
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        while (!ready1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready1_wait", ready1, 1'b1);
        exp1_q.push_back(2'(av) + 2'(bv) + 2'(cv));
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic waitDone8(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy8) busy_n++;
        end while (!done8 && lat < 40);
        checkOutput("done8_seen", done8, 1'b1);
    endtask

    task automatic waitDone1(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done1 && lat < 40);
        checkOutput("done1_seen", done1, 1'b1);
    endtask

    initial begin
        int lat, busy_n, spacing, seen;
        logic [7:0] sa, sb, sc;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(negedge clk);
        checkOutput("reset8_flags", {ready8, busy8, done8}, 3'b100);
        checkOutput("reset8_result", {cout8, sum8}, 9'h000);
        checkOutput("reset8_bits", {bit_a8, bit_b8, bit_cin8}, 3'b000);
        checkOutput("reset1_state", {ready1, busy1, done1, cout1, sum1, bit_a1, bit_b1, bit_cin1},
                    8'b1000_0000);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic add");
        applyStimulus8(8'h5A, 8'h33, 1'b0, 1'b0);
        waitDone8(lat, busy_n);
        checkOutput("basic_latency", lat, 9);
        checkOutput("basic_busy_cycles", busy_n, 8);
        checkOutput("basic_ready_in_done", ready8, 1'b0);
        @(negedge clk);
        checkOutput("basic_ready_after", {ready8, done8}, 2'b10);

        $display("[TB] carry ripple");
        applyStimulus8(8'hFF, 8'h01, 1'b0, 1'b0);
        waitDone8(lat, busy_n);
        applyStimulus8(8'hFF, 8'hFF, 1'b1, 1'b0);
        waitDone8(lat, busy_n);
        checkOutput("bits_zero_in_done", {bit_a8, bit_b8, bit_cin8}, 3'b000);

        $display("[TB] ignored start");
        applyStimulus8(8'h10, 8'h20, 1'b0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!done8) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                cin8 = 1'($urandom_range(0, 1));
            end
        end while (!done8 && lat < 40);
        checkOutput("held_done_seen", done8, 1'b1);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
        spacing = lat;
        do begin
            @(negedge clk);
            spacing++;
        end while (!ready8 && spacing < 40);
        checkOutput("start_spacing", spacing, 10);
        exp8_q.push_back(9'h007);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        waitDone8(lat, busy_n);
        checkOutput("held_second_latency", lat, 9);

        $display("[TB] reset mid-operation");
        applyStimulus8(8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        exp8_q.delete();
        #1;
        checkOutput("midrst_flags", {ready8, busy8, done8}, 3'b100);
        checkOutput("midrst_result", {cout8, sum8}, 9'h000);
        checkOutput("midrst_bits", {bit_a8, bit_b8, bit_cin8}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen++;
        end
        checkOutput("midrst_no_done", seen, 0);
        applyStimulus8(8'h01, 8'h02, 1'b0, 1'b0);
        waitDone8(lat, busy_n);
        checkOutput("after_rst_latency", lat, 9);

        $display("[TB] serial port");
        applyStimulus8(8'h81, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sa[i] = bit_a8;
            sb[i] = bit_b8;
            sc[i] = bit_cin8;
        end
        checkOutput("serial_bit_a", sa, 8'h81);
        checkOutput("serial_bit_b", sb, 8'h00);
        checkOutput("serial_bit_cin", sc, 8'h03);
        @(negedge clk);
        checkOutput("serial_done", done8, 1'b1);

        $display("[TB] random WIDTH=8");
        for (int n = 0; n < 1000; n++) begin
            applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            waitDone8(lat, busy_n);
            checkOutput("rand8_latency", lat, 9);
        end

        $display("[TB] WIDTH=1");
        applyStimulus1(1'b1, 1'b1, 1'b1);
        waitDone1(lat);
        checkOutput("w1_latency", lat, 2);
        for (int n = 0; n < 1000; n++) begin
            applyStimulus1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
            waitDone1(lat);
            checkOutput("rand1_latency", lat, 2);
        end

        repeat (3) @(negedge clk);
        checkOutput("queue8_drained", exp8_q.size(), 0);
        checkOutput("queue1_drained", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
